// File: rtl/sim_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sim_run_ctrl                                                 |
// | Description : Run controller for simulation and FPGA bring-up. Holds all   |
// |               reset channels for RST_HOLD cycles after rst_in drops, then  |
// |               releases them one by one, STAGGER cycles apart. After the    |
// |               last release it raises rdy_out and counts RUN cycles until   |
// |               a halt request or a cycle timeout ends the run. Status and   |
// |               exit code are latched until the next rst_in.                 |
// | Option      : define RUN_CTRL_STALL_EN to add a commit-stall watchdog      |
// |               (STALL_LIMIT consecutive RUN cycles without commit_in).      |
// | Ports       : clk_in        - system clock                                 |
// |               rst_in        - synchronous active-high reset                |
// |               halt_in       - program-done request (pulse or level)        |
// |               exit_code_in  - exit value, captured with halt_in            |
// |               commit_in     - instruction-commit strobe (stall option)     |
// |               rst_out       - per-channel active-high reset                |
// |               rdy_out       - core ready, high only while running          |
// |               done_out      - sticky, run ended by halt                    |
// |               timeout_out   - sticky, run ended by timeout or stall        |
// |               stall_out     - sticky, timeout caused by a stall            |
// |               exit_code_out - latched exit code                            |
// |               cycle_cnt_out - RUN cycle count                              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sim_run_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int RST_HOLD    = 25,
  parameter int STAGGER     = 1,
  parameter int TIMEOUT     = 15000000,
  parameter int CNT_W       = 32,
  parameter int STALL_LIMIT = 1024
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              halt_in,
  input  logic [7:0]        exit_code_in,
  input  logic              commit_in,
  output logic [NUM_CH-1:0] rst_out,
  output logic              rdy_out,
  output logic              done_out,
  output logic              timeout_out,
  output logic              stall_out,
  output logic [7:0]        exit_code_out,
  output logic [CNT_W-1:0]  cycle_cnt_out
);

  typedef enum logic [2:0] {
    S_HOLD = 3'd0,
    S_STAG = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3,
    S_TO   = 3'd4
  } state_t;

  // One phase counter serves both the hold window and the stagger gaps.
  localparam int PH_MAX = (RST_HOLD > STAGGER) ? RST_HOLD : STAGGER;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0]  C_HOLD_LAST = PH_W'(RST_HOLD - 1);
  localparam logic [PH_W-1:0]  C_STG_LAST  = PH_W'((STAGGER > 0) ? (STAGGER - 1) : 0);
  localparam logic [CNT_W-1:0] C_TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam bit               C_ALL_ONCE  = (NUM_CH == 1) || (STAGGER == 0);

  state_t              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [NUM_CH-1:0]   rst_q,   rst_d;
  logic                rdy_q,   rdy_d;
  logic                done_q,  done_d;
  logic                to_q,    to_d;
  logic                stall_q, stall_d;
  logic [7:0]          code_q,  code_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;

  logic                w_stall_hit;
  logic [NUM_CH-1:0]   w_rst_shift;

  // Channels release in ascending order: shifting the mask left by one clears
  // the lowest still-asserted channel, so an all-zero result means the last
  // channel is being released.
  assign w_rst_shift = rst_q << 1;

`ifdef RUN_CTRL_STALL_EN
  localparam int SC_W = $clog2(STALL_LIMIT + 1);
  localparam logic [SC_W-1:0] C_SC_LAST = SC_W'(STALL_LIMIT - 1);

  logic [SC_W-1:0] sc_q, sc_d;

  // Counter sits at zero outside RUN, so it is zero on RUN entry.
  always_comb begin
    sc_d        = '0;
    w_stall_hit = 1'b0;
    if (state_q == S_RUN) begin
      if (commit_in) begin
        sc_d = '0;
      end else begin
        sc_d        = sc_q + 1'b1;
        w_stall_hit = (sc_q == C_SC_LAST);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sc_q <= '0;
    end else begin
      sc_q <= sc_d;
    end
  end
`else
  logic w_unused_stall;
  assign w_stall_hit    = 1'b0;
  assign w_unused_stall = commit_in | (STALL_LIMIT < 1);
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rst_d   = rst_q;
    rdy_d   = rdy_q;
    done_d  = done_q;
    to_d    = to_q;
    stall_d = stall_q;
    code_d  = code_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_HOLD: begin
        if (phase_q == C_HOLD_LAST) begin
          phase_d = '0;
          if (C_ALL_ONCE) begin
            rst_d   = '0;
            rdy_d   = 1'b1;
            state_d = S_RUN;
          end else begin
            rst_d   = w_rst_shift;
            state_d = S_STAG;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      S_STAG: begin
        if (phase_q == C_STG_LAST) begin
          phase_d = '0;
          rst_d   = w_rst_shift;
          if (w_rst_shift == '0) begin
            rdy_d   = 1'b1;
            state_d = S_RUN;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      S_RUN: begin
        // The exiting edge is still a RUN cycle and is counted.
        cnt_d = cnt_q + 1'b1;
        if (halt_in) begin
          done_d  = 1'b1;
          rdy_d   = 1'b0;
          code_d  = exit_code_in;
          state_d = S_DONE;
        end else if (cnt_q == C_TO_LAST) begin
          to_d    = 1'b1;
          rdy_d   = 1'b0;
          state_d = S_TO;
        end else if (w_stall_hit) begin
          to_d    = 1'b1;
          stall_d = 1'b1;
          rdy_d   = 1'b0;
          state_d = S_TO;
        end
      end

      default: begin
        // DONE and TO are terminal; everything holds until rst_in.
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_HOLD;
      phase_q <= '0;
      rst_q   <= '1;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      stall_q <= 1'b0;
      code_q  <= 8'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rst_q   <= rst_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      to_q    <= to_d;
      stall_q <= stall_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rst_out       = rst_q;
  assign rdy_out       = rdy_q;
  assign done_out      = done_q;
  assign timeout_out   = to_q;
  assign stall_out     = stall_q;
  assign exit_code_out = code_q;
  assign cycle_cnt_out = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sim_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sim_run_ctrl                                              |
// | Description : Directed self-checking bench for sim_run_ctrl. Instance A:   |
// |               NUM_CH=3, RST_HOLD=4, STAGGER=2, TIMEOUT=16, STALL_LIMIT=8.  |
// |               Instance B: NUM_CH=2, RST_HOLD=25, STAGGER=0, TIMEOUT=40.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_sim_run_ctrl;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, halt, commit;
  logic [7:0] code;

  logic [2:0] a_rst;  logic a_rdy, a_done, a_to, a_stall;
  logic [7:0] a_code, a_cnt;
  logic [1:0] b_rst;  logic b_rdy, b_done, b_to, b_stall;
  logic [7:0] b_code, b_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sim_run_ctrl #(
    .NUM_CH(3), .RST_HOLD(4), .STAGGER(2), .TIMEOUT(16), .CNT_W(8), .STALL_LIMIT(8)
  ) u_dut_a (
    .clk_in(clk), .rst_in(rst_a), .halt_in(halt), .exit_code_in(code),
    .commit_in(commit), .rst_out(a_rst), .rdy_out(a_rdy), .done_out(a_done),
    .timeout_out(a_to), .stall_out(a_stall), .exit_code_out(a_code),
    .cycle_cnt_out(a_cnt)
  );

  sim_run_ctrl #(
    .NUM_CH(2), .RST_HOLD(25), .STAGGER(0), .TIMEOUT(40), .CNT_W(8), .STALL_LIMIT(8)
  ) u_dut_b (
    .clk_in(clk), .rst_in(rst_b), .halt_in(halt), .exit_code_in(code),
    .commit_in(commit), .rst_out(b_rst), .rdy_out(b_rdy), .done_out(b_done),
    .timeout_out(b_to), .stall_out(b_stall), .exit_code_out(b_code),
    .cycle_cnt_out(b_cnt)
  );

  // Advance one edge and settle; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Vector layout: {rst[2:0], rdy, done, timeout, stall, exit_code[7:0], cnt[7:0]}
  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; halt = 1'b0; commit = 1'b1; code = 8'h00;
    tick(); tick();
    n_cmp++;
    if ({a_rst, a_rdy, a_done, a_to, a_stall, a_code, a_cnt} !== {3'b111, 4'b0000, 8'h00, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_a: got %h want %h", {a_rst, a_rdy, a_done, a_to, a_stall, a_code, a_cnt},
               {3'b111, 4'b0000, 8'h00, 8'h00});
    end
    n_cmp++;
    if ({b_rst, b_rdy, b_done, b_to, b_stall, b_code, b_cnt} !== {2'b11, 4'b0000, 8'h00, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_b: got %h want %h", {b_rst, b_rdy, b_done, b_to, b_stall, b_code, b_cnt},
               {2'b11, 4'b0000, 8'h00, 8'h00});
    end
  endtask

  // Edge-by-edge release: 110 at edge 4, 100 at 6, 000 + rdy at 8, counting after.
  task automatic test_stagger(input bit do_reset);
    logic [2:0] e_rst;
    logic [7:0] e_cnt;
    if (do_reset) begin
      rst_a = 1'b1;
      tick();
    end
    rst_a = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      e_rst = (e < 4) ? 3'b111 : (e < 6) ? 3'b110 : (e < 8) ? 3'b100 : 3'b000;
      e_cnt = (e >= 8) ? 8'(e - 8) : 8'h00;
      n_cmp++;
      if ({a_rst, a_rdy, a_done, a_to, a_stall, a_code, a_cnt} !==
          {e_rst, (e >= 8), 3'b000, 8'h00, e_cnt}) begin
        n_bad++;
        $display("FAIL stagger_edge%0d: got %h want %h", e,
                 {a_rst, a_rdy, a_done, a_to, a_stall, a_code, a_cnt},
                 {e_rst, (e >= 8), 3'b000, 8'h00, e_cnt});
      end
    end
  endtask

  task automatic test_reset_mid_stagger();
    rst_a = 1'b1; tick();
    rst_a = 1'b0;
    repeat (6) tick();
    n_cmp++;
    if (a_rst !== 3'b100) begin
      n_bad++;
      $display("FAIL mid_stagger_rst: got %b want %b", a_rst, 3'b100);
    end
    rst_a = 1'b1; tick();
    n_cmp++;
    if ({a_rst, a_rdy, a_done, a_to, a_stall, a_code, a_cnt} !== {3'b111, 4'b0000, 8'h00, 8'h00}) begin
      n_bad++;
      $display("FAIL mid_stagger_reset: got %h want %h",
               {a_rst, a_rdy, a_done, a_to, a_stall, a_code, a_cnt}, {3'b111, 4'b0000, 8'h00, 8'h00});
    end
    test_stagger(1'b0);
  endtask

  task automatic test_halt();
    rst_a = 1'b1; tick();
    rst_a = 1'b0;
    repeat (8) tick();
    repeat (10) tick();
    n_cmp++;
    if ({a_rdy, a_cnt} !== {1'b1, 8'd10}) begin
      n_bad++;
      $display("FAIL halt_prerun: got %h want %h", {a_rdy, a_cnt}, {1'b1, 8'd10});
    end
    halt = 1'b1; code = 8'h5A; tick();
    halt = 1'b0; code = 8'h00;
    n_cmp++;
    if ({a_rst, a_rdy, a_done, a_to, a_stall, a_code, a_cnt} !== {3'b000, 4'b0100, 8'h5A, 8'd11}) begin
      n_bad++;
      $display("FAIL halt_done: got %h want %h",
               {a_rst, a_rdy, a_done, a_to, a_stall, a_code, a_cnt}, {3'b000, 4'b0100, 8'h5A, 8'd11});
    end
    halt = 1'b1; code = 8'hA5; tick();
    halt = 1'b0; code = 8'h00;
    repeat (3) tick();
    n_cmp++;
    if ({a_rst, a_rdy, a_done, a_to, a_stall, a_code, a_cnt} !== {3'b000, 4'b0100, 8'h5A, 8'd11}) begin
      n_bad++;
      $display("FAIL halt_ignored: got %h want %h",
               {a_rst, a_rdy, a_done, a_to, a_stall, a_code, a_cnt}, {3'b000, 4'b0100, 8'h5A, 8'd11});
    end
    rst_a = 1'b1; tick();
    n_cmp++;
    if ({a_rst, a_rdy, a_done, a_to, a_stall, a_code, a_cnt} !== {3'b111, 4'b0000, 8'h00, 8'h00}) begin
      n_bad++;
      $display("FAIL done_reset: got %h want %h",
               {a_rst, a_rdy, a_done, a_to, a_stall, a_code, a_cnt}, {3'b111, 4'b0000, 8'h00, 8'h00});
    end
  endtask

  task automatic test_timeout();
    rst_a = 1'b1; tick();
    rst_a = 1'b0;
`ifdef RUN_CTRL_STALL_EN
    commit = 1'b1;
`else
    commit = 1'b0;
`endif
    repeat (8) tick();
    repeat (15) tick();
    n_cmp++;
    if ({a_rdy, a_to, a_cnt} !== {1'b1, 1'b0, 8'd15}) begin
      n_bad++;
      $display("FAIL timeout_pre: got %h want %h", {a_rdy, a_to, a_cnt}, {1'b1, 1'b0, 8'd15});
    end
    tick();
    n_cmp++;
    if ({a_rst, a_rdy, a_done, a_to, a_stall, a_code, a_cnt} !== {3'b000, 4'b0010, 8'h00, 8'd16}) begin
      n_bad++;
      $display("FAIL timeout_hit: got %h want %h",
               {a_rst, a_rdy, a_done, a_to, a_stall, a_code, a_cnt}, {3'b000, 4'b0010, 8'h00, 8'd16});
    end
    halt = 1'b1; code = 8'h33; tick();
    halt = 1'b0; code = 8'h00; tick();
    n_cmp++;
    if ({a_rst, a_rdy, a_done, a_to, a_stall, a_code, a_cnt} !== {3'b000, 4'b0010, 8'h00, 8'd16}) begin
      n_bad++;
      $display("FAIL timeout_hold: got %h want %h",
               {a_rst, a_rdy, a_done, a_to, a_stall, a_code, a_cnt}, {3'b000, 4'b0010, 8'h00, 8'd16});
    end
    commit = 1'b1;
  endtask

  task automatic test_halt_at_timeout();
    rst_a = 1'b1; tick();
    rst_a = 1'b0;
    repeat (8) tick();
    repeat (15) tick();
    halt = 1'b1; code = 8'hC3; tick();
    halt = 1'b0; code = 8'h00;
    n_cmp++;
    if ({a_rst, a_rdy, a_done, a_to, a_stall, a_code, a_cnt} !== {3'b000, 4'b0100, 8'hC3, 8'd16}) begin
      n_bad++;
      $display("FAIL halt_beats_timeout: got %h want %h",
               {a_rst, a_rdy, a_done, a_to, a_stall, a_code, a_cnt}, {3'b000, 4'b0100, 8'hC3, 8'd16});
    end
  endtask

  task automatic test_no_stagger();
    rst_b = 1'b1; tick();
    rst_b = 1'b0;
    repeat (24) tick();
    n_cmp++;
    if ({b_rst, b_rdy, b_cnt} !== {2'b11, 1'b0, 8'd0}) begin
      n_bad++;
      $display("FAIL nostag_edge24: got %h want %h", {b_rst, b_rdy, b_cnt}, {2'b11, 1'b0, 8'd0});
    end
    tick();
    n_cmp++;
    if ({b_rst, b_rdy, b_done, b_to, b_stall, b_cnt} !== {2'b00, 4'b1000, 8'd0}) begin
      n_bad++;
      $display("FAIL nostag_edge25: got %h want %h",
               {b_rst, b_rdy, b_done, b_to, b_stall, b_cnt}, {2'b00, 4'b1000, 8'd0});
    end
    tick();
    n_cmp++;
    if ({b_rdy, b_cnt} !== {1'b1, 8'd1}) begin
      n_bad++;
      $display("FAIL nostag_count: got %h want %h", {b_rdy, b_cnt}, {1'b1, 8'd1});
    end
  endtask

`ifdef RUN_CTRL_STALL_EN
  task automatic test_stall();
    rst_a = 1'b1; tick();
    rst_a = 1'b0; commit = 1'b0;
    repeat (8) tick();
    repeat (7) tick();
    n_cmp++;
    if ({a_rdy, a_to, a_stall} !== 3'b100) begin
      n_bad++;
      $display("FAIL stall_pre: got %b want %b", {a_rdy, a_to, a_stall}, 3'b100);
    end
    tick();
    n_cmp++;
    if ({a_rdy, a_done, a_to, a_stall, a_cnt} !== {4'b0011, 8'd8}) begin
      n_bad++;
      $display("FAIL stall_hit: got %h want %h", {a_rdy, a_done, a_to, a_stall, a_cnt}, {4'b0011, 8'd8});
    end
    // Commit on every 7th RUN edge keeps the watchdog quiet until the cycle timeout.
    rst_a = 1'b1; tick();
    rst_a = 1'b0;
    repeat (8) tick();
    for (int e = 1; e <= 15; e++) begin
      commit = (e % 7 == 0);
      tick();
    end
    commit = 1'b0;
    n_cmp++;
    if ({a_rdy, a_to, a_stall, a_cnt} !== {3'b100, 8'd15}) begin
      n_bad++;
      $display("FAIL stall_avoided: got %h want %h", {a_rdy, a_to, a_stall, a_cnt}, {3'b100, 8'd15});
    end
    tick();
    n_cmp++;
    if ({a_rdy, a_to, a_stall, a_cnt} !== {3'b010, 8'd16}) begin
      n_bad++;
      $display("FAIL cycle_timeout_no_stall: got %h want %h", {a_rdy, a_to, a_stall, a_cnt}, {3'b010, 8'd16});
    end
    commit = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_stagger(1'b1);
    test_reset_mid_stagger();
    test_halt();
    test_timeout();
    test_halt_at_timeout();
    test_no_stagger();
`ifdef RUN_CTRL_STALL_EN
    test_stall();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
